// File: rtl/ldpc_syndrome_encoder_pkg.sv
// ldpc_pkg: shared LDPC code definitions.
// Holds the block length N, the syndrome length M, the state encoding of the
// syndrome encoder, and the parity-check matrix H_ROWS (M row masks of N
// bits). The decoder's check-node unit uses the same H_ROWS, so that both ends
// of the reconciliation link agree on the code.
// Optional build macro used by files importing this package: LDPC_LEAK_CNT_EN.
package ldpc_pkg;

    localparam int N = 100;
    localparam int M = 50;

    typedef logic [N-1:0]         h_row_t;
    typedef logic [M-1:0][N-1:0]  h_mat_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        HOLD    = 2'd2
    } enc_state_t;

    // Column-regular construction: every key bit c feeds up to three checks.
    // When two of the row indices coincide, the bit still appears in that row
    // only once, so a few columns end up with weight 2.
    function automatic h_mat_t gen_h_rows();
        h_mat_t h;
        h = '0;
        for (int c = 0; c < N; c++) begin
            h[c % M][c]            = 1'b1;
            h[(3 * c + 7) % M][c]  = 1'b1;
            h[(7 * c + 13) % M][c] = 1'b1;
        end
        return h;
    endfunction

    localparam h_mat_t H_ROWS = gen_h_rows();

endpackage

// File: rtl/ldpc_syndrome_encoder_if.sv
// ldpc_syndrome_encoder_if: request/result bundle of the syndrome encoder.
//   x_i        key block, sampled when a request is accepted
//   start      request, accepted when start && ready
//   ready      encoder idle
//   busy       encoder computing or holding a result
//   syndrome   H*x over GF(2)
//   syn_valid  syndrome complete, held until syn_ack
//   syn_ack    consumer acknowledge
//   leak_bits  cumulative disclosed syndrome bits (LDPC_LEAK_CNT_EN only)
// master = requester/consumer side, slave = encoder side.
// Build macro: LDPC_LEAK_CNT_EN.
interface ldpc_syndrome_encoder_if
    import ldpc_pkg::*;
`ifdef LDPC_LEAK_CNT_EN
    #(parameter int LEAK_W = 16)
`endif
    ();

    logic [N-1:0] x_i;
    logic         start;
    logic         ready;
    logic         busy;
    logic [M-1:0] syndrome;
    logic         syn_valid;
    logic         syn_ack;
`ifdef LDPC_LEAK_CNT_EN
    logic [LEAK_W-1:0] leak_bits;
`endif

    modport master (
        output x_i, start, syn_ack,
        input  ready, busy, syndrome, syn_valid
`ifdef LDPC_LEAK_CNT_EN
        , input leak_bits
`endif
    );

    modport slave (
        input  x_i, start, syn_ack,
        output ready, busy, syndrome, syn_valid
`ifdef LDPC_LEAK_CNT_EN
        , output leak_bits
`endif
    );

endinterface

// File: rtl/ldpc_syndrome_encoder_h_rom.sv
// ldpc_h_rom: combinational H-matrix row fetch.
//   row_base  in   index of the first row of the group
//   rows      out  ROWS_PER_CYC masks H_ROWS[row_base + k]; rows beyond M read 0
// Isolated so the constant H source can later become a block RAM.
module ldpc_h_rom
    import ldpc_pkg::*;
#(
    parameter int ROWS_PER_CYC = 5,
    parameter int RCW          = $clog2(M + 1)
) (
    input  logic [RCW-1:0]                  row_base,
    output logic [ROWS_PER_CYC-1:0][N-1:0]  rows
);

    always_comb begin
        rows = '0;
        for (int k = 0; k < ROWS_PER_CYC; k++) begin
            logic [RCW-1:0] idx;
            idx = row_base + RCW'(k);
            if (idx < RCW'(M)) begin
                rows[k] = H_ROWS[idx];
            end
        end
    end

endmodule

// File: rtl/ldpc_syndrome_encoder.sv
// ldpc_syndrome_encoder: transmit-side syndrome generator, s = H*x over GF(2).
//   clk    in  clock, rising edge
//   rst_n  in  asynchronous active-low reset
//   bus    slave modport of ldpc_syndrome_encoder_if (x_i, start, ready, busy,
//          syndrome, syn_valid, syn_ack, and leak_bits when enabled)
// A block is latched on start && ready, ROWS_PER_CYC syndrome rows are
// evaluated per clock, and the finished syndrome is held until syn_ack.
// Build macro: LDPC_LEAK_CNT_EN adds a saturating count of disclosed bits.
module ldpc_syndrome_encoder
    import ldpc_pkg::*;
#(
    parameter int ROWS_PER_CYC = 5
`ifdef LDPC_LEAK_CNT_EN
    , parameter int LEAK_W = 16
`endif
) (
    input  logic                      clk,
    input  logic                      rst_n,
    ldpc_syndrome_encoder_if.slave    bus
);

    localparam int RCW       = $clog2(M + 1);
    localparam int LAST_BASE = M - ROWS_PER_CYC;

    if (M % ROWS_PER_CYC != 0) begin : g_bad_rows_per_cyc
        $error("ldpc_syndrome_encoder: M must be a multiple of ROWS_PER_CYC");
    end

    enc_state_t                      state;
    enc_state_t                      state_nxt;
    logic                            accept;
    logic                            last_group;
    logic [N-1:0]                    x_reg;
    logic [M-1:0]                    syndrome;
    logic                            syn_valid;
    logic [RCW-1:0]                  row_cnt;
    logic [ROWS_PER_CYC-1:0][N-1:0]  h_rows;
    logic [ROWS_PER_CYC-1:0]         par;

    ldpc_h_rom #(
        .ROWS_PER_CYC (ROWS_PER_CYC),
        .RCW          (RCW)
    ) u_h_rom (
        .row_base (row_cnt),
        .rows     (h_rows)
    );

    always_comb begin
        par = '0;
        for (int k = 0; k < ROWS_PER_CYC; k++) begin
            par[k] = ^(x_reg & h_rows[k]);
        end
    end

    assign last_group = (row_cnt == RCW'(LAST_BASE));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    accept    = 1'b1;
                    state_nxt = COMPUTE;
                end
            end
            COMPUTE: begin
                if (last_group) begin
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                // start on the ack edge is deliberately not looked at here.
                if (bus.syn_ack) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_reg     <= '0;
            syndrome  <= '0;
            row_cnt   <= '0;
            syn_valid <= 1'b0;
        end else begin
            if (accept) begin
                x_reg    <= bus.x_i;
                syndrome <= '0;
                row_cnt  <= '0;
            end else if (state == COMPUTE) begin
                syndrome[row_cnt +: ROWS_PER_CYC] <= par;
                row_cnt                           <= row_cnt + RCW'(ROWS_PER_CYC);
            end

            if (state == COMPUTE && last_group) begin
                syn_valid <= 1'b1;
            end else if (state == HOLD && bus.syn_ack) begin
                syn_valid <= 1'b0;
            end
        end
    end

`ifdef LDPC_LEAK_CNT_EN
    logic [LEAK_W-1:0] leak_bits;
    logic [LEAK_W:0]   leak_sum;

    // One extra bit catches the carry; on overflow clamp to all ones.
    assign leak_sum = {1'b0, leak_bits} + (LEAK_W + 1)'(M);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            leak_bits <= '0;
        end else if (state == HOLD && bus.syn_ack) begin
            leak_bits <= leak_sum[LEAK_W] ? '1 : leak_sum[LEAK_W-1:0];
        end
    end

    assign bus.leak_bits = leak_bits;
`endif

    assign bus.ready     = (state == IDLE);
    assign bus.busy      = (state != IDLE);
    assign bus.syndrome  = syndrome;
    assign bus.syn_valid = syn_valid;

endmodule

// File: tb/tb_ldpc_syndrome_encoder.sv
// tb_ldpc_syndrome_encoder: randomized self-checking bench for
// ldpc_syndrome_encoder. Expected syndromes come from a row-by-row count of
// shared key/check positions taken modulo 2. Build macro: LDPC_LEAK_CNT_EN
// enables the leakage-counter scenarios.
module tb_ldpc_syndrome_encoder;
    import ldpc_pkg::*;

    localparam int LAT = 10;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    ldpc_syndrome_encoder_if bus ();

    ldpc_syndrome_encoder #(.ROWS_PER_CYC(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_err = 0;
    int leak_ref = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [M-1:0] ref_syndrome(input logic [N-1:0] x);
        logic [M-1:0] s;
        for (int r = 0; r < M; r++) begin
            int shared;
            shared = 0;
            for (int c = 0; c < N; c++) begin
                if (x[c] == 1'b1 && H_ROWS[r][c] == 1'b1) shared++;
            end
            s[r] = (shared % 2 == 1);
        end
        return s;
    endfunction

    function automatic logic [N-1:0] rand_block();
        logic [127:0] w;
        w = {$urandom, $urandom, $urandom, $urandom};
        return w[N-1:0];
    endfunction

    task automatic apply_reset();
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.syn_ack = 1'b0;
        bus.x_i = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", bus.ready, 1'b1);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_valid", bus.syn_valid, 1'b0);
        chk("rst_syndrome", bus.syndrome, '0);
`ifdef LDPC_LEAK_CNT_EN
        chk("rst_leak", bus.leak_bits, '0);
        leak_ref = 0;
`endif
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Accept one block and wait for syn_valid; returns with syn_valid high
    // (or after a bounded timeout), #1 after the completing edge.
    task automatic launch_and_wait(input logic [N-1:0] x, input logic [M-1:0] exp, input string tag);
        int lat;
        chk({tag, "_ready_pre"}, bus.ready, 1'b1);
        bus.x_i = x;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.x_i = rand_block();
        lat = 0;
        do begin
            chk({tag, "_busy"}, {bus.busy, bus.ready}, 2'b10);
            @(posedge clk);
            #1;
            lat++;
        end while (!bus.syn_valid && lat < 100);
        chk({tag, "_latency"}, lat, LAT);
        chk({tag, "_syndrome"}, bus.syndrome, exp);
    endtask

    task automatic ack_block(input logic [M-1:0] exp, input string tag);
        bus.syn_ack = 1'b1;
        @(posedge clk);
        #1;
        bus.syn_ack = 1'b0;
        leak_ref = (leak_ref + M > 65535) ? 65535 : leak_ref + M;
        chk({tag, "_ack_state"}, {bus.ready, bus.busy, bus.syn_valid}, 3'b100);
        chk({tag, "_ack_syn_kept"}, bus.syndrome, exp);
    endtask

    task automatic run_block(input logic [N-1:0] x, input logic [M-1:0] exp, input int ack_dly, input string tag);
        launch_and_wait(x, exp, tag);
        for (int i = 0; i < ack_dly; i++) begin
            bus.syn_ack = 1'b0;
            @(posedge clk);
            #1;
            chk({tag, "_hold"}, {bus.syn_valid, bus.ready, bus.syndrome}, {1'b1, 1'b0, exp});
        end
        ack_block(exp, tag);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [N-1:0] x;
        logic [M-1:0] e;

        apply_reset();

        // All-zero key block.
        run_block('0, '0, 0, "zero");

        // Single-bit keys select one column of H.
        foreach (e[r]) e[r] = H_ROWS[r][0];
        x = '0; x[0] = 1'b1;
        run_block(x, e, 1, "col0");
        foreach (e[r]) e[r] = H_ROWS[r][37];
        x = '0; x[37] = 1'b1;
        run_block(x, e, 0, "col37");
        foreach (e[r]) e[r] = H_ROWS[r][99];
        x = '0; x[99] = 1'b1;
        run_block(x, e, 2, "col99");

        // All-ones key: each syndrome bit is the parity of the row weight.
        foreach (e[r]) e[r] = ($countones(H_ROWS[r]) % 2 == 1);
        run_block('1, e, 0, "ones");

        // Long hold with start pulses; ack coincides with start.
        x = rand_block();
        e = ref_syndrome(x);
        launch_and_wait(x, e, "hold");
        for (int i = 0; i < 20; i++) begin
            bus.start = i[0];
            bus.x_i = rand_block();
            @(posedge clk);
            #1;
            chk("hold_stable", {bus.syn_valid, bus.ready, bus.busy, bus.syndrome}, {3'b101, e});
        end
        bus.start = 1'b1;
        ack_block(e, "hold");
        bus.start = 1'b0;
        @(posedge clk);
        #1;
        chk("hold_no_accept", {bus.ready, bus.busy}, 2'b10);

        // Reset at the 5th compute edge aborts the block.
        x = rand_block();
        bus.x_i = x;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_state", {bus.ready, bus.busy, bus.syn_valid}, 3'b100);
        chk("abort_syndrome", bus.syndrome, '0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        leak_ref = 0;
        x = rand_block();
        run_block(x, ref_syndrome(x), 0, "after_abort");

        // Randomized traffic.
        for (int b = 0; b < 30; b++) begin
            x = rand_block();
            run_block(x, ref_syndrome(x), $urandom_range(0, 3), "rand");
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end

`ifdef LDPC_LEAK_CNT_EN
        apply_reset();
        for (int b = 0; b < 3; b++) begin
            x = rand_block();
            run_block(x, ref_syndrome(x), 0, "leak3");
        end
        chk("leak_150", bus.leak_bits, 150);
        for (int b = 3; b < 1311; b++) begin
            x = rand_block();
            run_block(x, ref_syndrome(x), 0, "leaksat");
            if (b == 1309) chk("leak_before_sat", bus.leak_bits, leak_ref);
        end
        chk("leak_sat", bus.leak_bits, 65535);
        run_block('0, '0, 0, "leak_stay");
        chk("leak_stay_sat", bus.leak_bits, 65535);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
